// File: rtl/led_cycle_ctrl.sv
// rtl/led_cycle_ctrl.sv - debounced 5-button speed selector driving a one-cycle LED step strobe
// Define LED_CYCLE_CTRL_PAUSE_EN to let a same-level press toggle RUN/PAUSE.
module led_cycle_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BASE_DIV        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] buttons,
  output logic       step,
  output logic [2:0] speed_sel,
  output logic       running
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam int            PW      = $clog2(16 * BASE_DIV);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {RUN, PAUSE} state_t;

  state_t        state_q, state_d;
  logic [4:0]    sync1_q, sync2_q;
  logic [4:0]    stable_q, stable_d;
  logic [4:0]    press_w;
  logic [CW-1:0] db_cnt_q [5];
  logic [CW-1:0] db_cnt_d [5];
  logic [2:0]    speed_q, speed_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [PW-1:0] presc_last_w;
  logic [31:0]   period_w;
  logic [2:0]    win_w;
  logic          evt_w;
  logic          do_count_w;

  // A press event fires in the cycle the stable bit is about to rise.
  always_comb begin
    stable_d = stable_q;
    press_w  = '0;
    for (int i = 0; i < 5; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
          press_w[i]  = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    win_w = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (press_w[i]) win_w = 3'(i);
    end
    evt_w = |press_w;
  end

  assign period_w     = 32'(BASE_DIV) << (3'd4 - speed_q);
  assign presc_last_w = PW'(period_w - 32'd1);

  always_comb begin
    state_d    = state_q;
    speed_d    = speed_q;
    presc_d    = presc_q;
    step       = 1'b0;
    do_count_w = (state_q == RUN);
    if (evt_w && (win_w != speed_q)) begin
      speed_d    = win_w;
      presc_d    = '0;
      state_d    = RUN;
      do_count_w = 1'b0;
    end
`ifdef LED_CYCLE_CTRL_PAUSE_EN
    else if (evt_w) begin
      state_d    = (state_q == RUN) ? PAUSE : RUN;
      do_count_w = 1'b0;
    end
`endif
    if (do_count_w) begin
      if (presc_q == presc_last_w) begin
        step    = 1'b1;
        presc_d = '0;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= '0;
      state_q  <= RUN;
      speed_q  <= '0;
      presc_q  <= '0;
    end else begin
      sync1_q  <= buttons;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q  <= state_d;
      speed_q  <= speed_d;
      presc_q  <= presc_d;
    end
  end

  assign speed_sel = speed_q;
  assign running   = (state_q == RUN);

endmodule
